// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared state encoding, ALU opcode values and index helpers
// for the ALU bus sequencer.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    EXEC   = 3'd3,
    TURN   = 3'd4,
    WRITE  = 3'd5,
    DONE   = 3'd6,
    ERR    = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } alu_op_e;

  // True when a register index addresses an existing general register.
  function automatic logic idx_in_range(input int unsigned idx,
                                        input int unsigned num_regs);
    return idx < num_regs;
  endfunction

endpackage

// File: rtl/alu_bus_sequencer_if.sv
// alu_bus_sequencer_if: command handshake plus Bus drive/load strobes between
// the instruction decoder, the sequencer and the register file / ALU.
// master = decoder/datapath side, slave = sequencer side.
interface alu_bus_sequencer_if #(
  parameter int NumRegs  = 4,
  parameter int IdxWidth = 4,
  parameter int OpWidth  = 3
);

  logic                CmdValid;
  logic                CmdReady;
  logic [IdxWidth-1:0] CmdSrcA;
  logic [IdxWidth-1:0] CmdSrcB;
  logic [IdxWidth-1:0] CmdDst;
  logic [OpWidth-1:0]  CmdOp;

  logic [NumRegs-1:0]  RegOutSel;
  logic [NumRegs-1:0]  RegInSel;
  logic                AluAIn;
  logic                AluBIn;
  logic                AluOut;
  logic [OpWidth-1:0]  AluOp;
  logic                Done;
  logic                Err;

  modport master (
    output CmdValid, CmdSrcA, CmdSrcB, CmdDst, CmdOp,
    input  CmdReady, RegOutSel, RegInSel, AluAIn, AluBIn, AluOut, AluOp,
           Done, Err
  );

  modport slave (
    input  CmdValid, CmdSrcA, CmdSrcB, CmdDst, CmdOp,
    output CmdReady, RegOutSel, RegInSel, AluAIn, AluBIn, AluOut, AluOp,
           Done, Err
  );

endinterface

// File: rtl/idx_onehot_decoder.sv
// idx_onehot_decoder: binary register index to one-hot select with enable.
// Indices at or beyond NumRegs decode to all zeros, so a bad index can never
// produce a strobe.
module idx_onehot_decoder #(
  parameter int IdxWidth = 4,
  parameter int NumRegs  = 4
) (
  input  logic [IdxWidth-1:0] idx,
  input  logic                en,
  output logic [NumRegs-1:0]  onehot
);

  // Compare the index against every register slot.
  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < NumRegs; i++) begin
      if (en && (32'(idx) == i)) begin
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_bus_sequencer.sv
// alu_bus_sequencer: multi-cycle controller running one ALU operation over the
// shared Bus: drive SrcA into operand A, SrcB into operand B, wait ExecCycles,
// then drive the ALU result into Dst. All outputs are registered.
// Optional macro BUS_TURNAROUND_EN inserts an idle TURN cycle after LOAD_A and
// another before WRITE.
module alu_bus_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NumRegs    = 4,
  parameter int IdxWidth   = 4,
  parameter int OpWidth    = 3,
  parameter int ExecCycles = 1
) (
  input logic                Clk,
  input logic                Rst,
  alu_bus_sequencer_if.slave bus
);

  // Counter preload: EXEC lasts ExecCycles cycles, leaving when the count is 0.
  localparam logic [3:0] ExecLoad = (ExecCycles > 0) ? 4'(ExecCycles - 1) : 4'd0;

`ifdef BUS_TURNAROUND_EN
  localparam state_t AfterLoadA = TURN;
  localparam state_t PreWrite   = TURN;
`else
  localparam state_t AfterLoadA = LOAD_B;
  localparam state_t PreWrite   = WRITE;
`endif

  state_t              state;
  state_t              state_next;
  logic [IdxWidth-1:0] src_a_q, src_b_q, dst_q;
  logic [IdxWidth-1:0] src_a_n, src_b_n, dst_n;
  logic [OpWidth-1:0]  op_q, op_n;
  logic [3:0]          exec_cnt, exec_cnt_n;
  logic                cmd_ok;

  logic [IdxWidth-1:0] out_idx;
  logic                out_en;
  logic                in_en;
  logic [NumRegs-1:0]  out_dec;
  logic [NumRegs-1:0]  in_dec;

  logic                cmd_ready_q;
  logic [NumRegs-1:0]  reg_out_q;
  logic [NumRegs-1:0]  reg_in_q;
  logic                alu_a_in_q;
  logic                alu_b_in_q;
  logic                alu_out_q;
  logic                done_q;
  logic                err_q;

`ifdef BUS_TURNAROUND_EN
  // The single TURN state is shared; this flag records whether it precedes
  // LOAD_B (clear) or WRITE (set).
  logic turn_late;

  // Remember which TURN occurrence is being entered.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      turn_late <= 1'b0;
    end else begin
      turn_late <= (state_next == TURN) && (state != LOAD_A);
    end
  end
`endif

  // Every captured index must address an existing register.
  always_comb begin
    cmd_ok = idx_in_range(32'(bus.CmdSrcA), NumRegs) &&
             idx_in_range(32'(bus.CmdSrcB), NumRegs) &&
             idx_in_range(32'(bus.CmdDst),  NumRegs);
  end

  // Next-state, command capture and EXEC counter logic.
  always_comb begin
    state_next = state;
    src_a_n    = src_a_q;
    src_b_n    = src_b_q;
    dst_n      = dst_q;
    op_n       = op_q;
    exec_cnt_n = exec_cnt;
    case (state)
      IDLE: begin
        if (bus.CmdValid) begin
          src_a_n    = bus.CmdSrcA;
          src_b_n    = bus.CmdSrcB;
          dst_n      = bus.CmdDst;
          op_n       = bus.CmdOp;
          state_next = cmd_ok ? LOAD_A : ERR;
        end
      end
      LOAD_A: state_next = AfterLoadA;
      LOAD_B: begin
        if (ExecCycles == 0) begin
          state_next = PreWrite;
        end else begin
          state_next = EXEC;
          exec_cnt_n = ExecLoad;
        end
      end
      EXEC: begin
        if (exec_cnt == '0) begin
          state_next = PreWrite;
        end else begin
          exec_cnt_n = exec_cnt - 4'd1;
        end
      end
`ifdef BUS_TURNAROUND_EN
      TURN:   state_next = turn_late ? WRITE : LOAD_B;
`endif
      WRITE:  state_next = DONE;
      DONE:   state_next = IDLE;
      ERR:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they register in the same
  // edge that enters it; on accept the indices come straight from the command.
  always_comb begin
    out_idx = (state_next == LOAD_A) ? src_a_n : src_b_n;
    out_en  = (state_next == LOAD_A) || (state_next == LOAD_B);
    in_en   = (state_next == WRITE);
  end

  idx_onehot_decoder #(
    .IdxWidth (IdxWidth),
    .NumRegs  (NumRegs)
  ) u_out_dec (
    .idx    (out_idx),
    .en     (out_en),
    .onehot (out_dec)
  );

  idx_onehot_decoder #(
    .IdxWidth (IdxWidth),
    .NumRegs  (NumRegs)
  ) u_in_dec (
    .idx    (dst_n),
    .en     (in_en),
    .onehot (in_dec)
  );

  // State, captured command fields and EXEC counter.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      src_a_q  <= '0;
      src_b_q  <= '0;
      dst_q    <= '0;
      op_q     <= '0;
      exec_cnt <= '0;
    end else begin
      state    <= state_next;
      src_a_q  <= src_a_n;
      src_b_q  <= src_b_n;
      dst_q    <= dst_n;
      op_q     <= op_n;
      exec_cnt <= exec_cnt_n;
    end
  end

  // Registered Moore outputs; reset leaves the Bus undriven and idle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cmd_ready_q <= 1'b1;
      reg_out_q   <= '0;
      reg_in_q    <= '0;
      alu_a_in_q  <= 1'b0;
      alu_b_in_q  <= 1'b0;
      alu_out_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cmd_ready_q <= (state_next == IDLE);
      reg_out_q   <= out_dec;
      reg_in_q    <= in_dec;
      alu_a_in_q  <= (state_next == LOAD_A);
      alu_b_in_q  <= (state_next == LOAD_B);
      alu_out_q   <= (state_next == WRITE);
      done_q      <= (state_next == DONE);
      err_q       <= (state_next == ERR);
    end
  end

  assign bus.CmdReady  = cmd_ready_q;
  assign bus.RegOutSel = reg_out_q;
  assign bus.RegInSel  = reg_in_q;
  assign bus.AluAIn    = alu_a_in_q;
  assign bus.AluBIn    = alu_b_in_q;
  assign bus.AluOut    = alu_out_q;
  assign bus.AluOp     = op_q;
  assign bus.Done      = done_q;
  assign bus.Err       = err_q;

endmodule

// File: tb/tb_alu_bus_sequencer.sv
// tb_alu_bus_sequencer: directed table-driven bench with a small register-file
// and ALU model on the Bus, plus hand-written multi-cycle sequences.
module tb_alu_bus_sequencer;
  import alu_seq_pkg::*;

  localparam int NumRegs    = 4;
  localparam int IdxWidth   = 4;
  localparam int OpWidth    = 3;
  localparam int ExecCycles = 1;
`ifdef BUS_TURNAROUND_EN
  localparam int TurnX = 1;
`else
  localparam int TurnX = 0;
`endif
  localparam int LoadBCyc = 2 + TurnX;
  localparam int WriteCyc = 3 + ExecCycles + 2 * TurnX;
  localparam int DoneCyc  = WriteCyc + 1;
  localparam int Interval = DoneCyc + 1;

  typedef struct {
    logic [3:0]  src_a;
    logic [3:0]  src_b;
    logic [3:0]  dst;
    logic [2:0]  op;
    logic [15:0] init_a;
    logic [15:0] init_b;
    logic [3:0]  sel_a;
    logic [3:0]  sel_b;
    logic [3:0]  sel_d;
    logic [15:0] result;
    logic        err;
  } vec_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   bus_viol = 0;

  alu_bus_sequencer_if #(
    .NumRegs  (NumRegs),
    .IdxWidth (IdxWidth),
    .OpWidth  (OpWidth)
  ) bus_if ();

  alu_bus_sequencer #(
    .NumRegs    (NumRegs),
    .IdxWidth   (IdxWidth),
    .OpWidth    (OpWidth),
    .ExecCycles (ExecCycles)
  ) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file / ALU environment
  logic [15:0] regs [NumRegs];
  logic [15:0] alu_a, alu_b, alu_res, bus_val;
  logic        ld_en;
  logic [1:0]  ld_idx;
  logic [15:0] ld_val;

  always_comb begin
    case (bus_if.AluOp)
      OP_ADD:  alu_res = alu_a + alu_b;
      OP_SUB:  alu_res = alu_a - alu_b;
      OP_AND:  alu_res = alu_a & alu_b;
      OP_OR:   alu_res = alu_a | alu_b;
      OP_XOR:  alu_res = alu_a ^ alu_b;
      OP_NOT:  alu_res = ~alu_a;
      OP_SHL:  alu_res = alu_a << 1;
      OP_SHR:  alu_res = alu_a >> 1;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    bus_val = '0;
    for (int i = 0; i < NumRegs; i++) begin
      if (bus_if.RegOutSel[i] === 1'b1) bus_val = regs[i];
    end
    if (bus_if.AluOut === 1'b1) bus_val = alu_res;
  end

  always @(posedge clk) begin
    if (ld_en) regs[ld_idx] <= ld_val;
    if (bus_if.AluAIn === 1'b1) alu_a <= bus_val;
    if (bus_if.AluBIn === 1'b1) alu_b <= bus_val;
    for (int i = 0; i < NumRegs; i++) begin
      if (bus_if.RegInSel[i] === 1'b1) regs[i] <= bus_val;
    end
  end

  // Bus ownership invariant, checked every cycle outside reset
  always @(negedge clk) begin
    if (!rst) begin
      if (($countones(bus_if.RegOutSel) + int'(bus_if.AluOut) > 1) ||
          ($countones(bus_if.RegInSel) > 1) ||
          ((bus_if.RegInSel != '0) && (bus_if.AluOut !== 1'b1))) begin
        bus_viol <= bus_viol + 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [16:0] cur_word();
    return {bus_if.RegOutSel, bus_if.RegInSel, bus_if.AluAIn, bus_if.AluBIn,
            bus_if.AluOut, bus_if.Done, bus_if.Err, bus_if.CmdReady, bus_if.AluOp};
  endfunction

  function automatic logic [16:0] exp_word(input vec_t v, input int k);
    logic [3:0] os, is;
    logic a, b, ao, d, e, r;
    os = '0; is = '0; a = 1'b0; b = 1'b0; ao = 1'b0; d = 1'b0; e = 1'b0; r = 1'b0;
    if (v.err) begin
      e = (k == 1);
      r = (k == 2);
    end else begin
      if (k == 1)        begin os = v.sel_a; a = 1'b1; end
      if (k == LoadBCyc) begin os = v.sel_b; b = 1'b1; end
      if (k == WriteCyc) begin is = v.sel_d; ao = 1'b1; end
      d = (k == DoneCyc);
      r = (k == DoneCyc + 1);
    end
    return {os, is, a, b, ao, d, e, r, v.op};
  endfunction

  task automatic preload(input int idx, input logic [15:0] val);
    if (idx < NumRegs) begin
      @(negedge clk);
      ld_en  = 1'b1;
      ld_idx = 2'(idx);
      ld_val = val;
      @(posedge clk);
      #1 ld_en = 1'b0;
    end
  endtask

  task automatic drive_cmd(input vec_t v);
    bus_if.CmdSrcA = v.src_a;
    bus_if.CmdSrcB = v.src_b;
    bus_if.CmdDst  = v.dst;
    bus_if.CmdOp   = v.op;
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int n;
    preload(int'(v.src_a), v.init_a);
    preload(int'(v.src_b), v.init_b);
    @(negedge clk);
    check($sformatf("vec%0d_ready", id), 32'(bus_if.CmdReady), 32'd1);
    drive_cmd(v);
    bus_if.CmdValid = 1'b1;
    @(posedge clk);
    #1 bus_if.CmdValid = 1'b0;
    n = v.err ? 2 : DoneCyc + 1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      check($sformatf("vec%0d_cyc%0d", id, k), 32'(cur_word()), 32'(exp_word(v, k)));
    end
    if (!v.err) check($sformatf("vec%0d_result", id), 32'(regs[v.dst[1:0]]), 32'(v.result));
  endtask

  vec_t vecs [10];
  vec_t b2b  [3];
  logic [16:0] reset_word;

  initial begin
    int idx, last_done, prev_acc;
    logic got_done;

    vecs[0] = '{4'd1, 4'd2, 4'd3, OP_ADD, 16'h0005, 16'h0003, 4'b0010, 4'b0100, 4'b1000, 16'h0008, 1'b0};
    vecs[1] = '{4'd0, 4'd0, 4'd0, OP_SUB, 16'h1234, 16'h1234, 4'b0001, 4'b0001, 4'b0001, 16'h0000, 1'b0};
    vecs[2] = '{4'd2, 4'd1, 4'd0, OP_XOR, 16'h00FF, 16'h0F0F, 4'b0100, 4'b0010, 4'b0001, 16'h0FF0, 1'b0};
    vecs[3] = '{4'd3, 4'd3, 4'd1, OP_SHL, 16'h8001, 16'h8001, 4'b1000, 4'b1000, 4'b0010, 16'h0002, 1'b0};
    vecs[4] = '{4'd0, 4'd2, 4'd2, OP_AND, 16'hF0F0, 16'h3C3C, 4'b0001, 4'b0100, 4'b0100, 16'h3030, 1'b0};
    vecs[5] = '{4'd1, 4'd2, 4'd5, OP_XOR, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 16'h0000, 1'b1};
    vecs[6] = '{4'd4, 4'd0, 4'd1, OP_OR,  16'h0000, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 16'h0000, 1'b1};
    vecs[7] = '{4'd1, 4'd0, 4'd1, OP_OR,  16'h0101, 16'h1010, 4'b0010, 4'b0001, 4'b0010, 16'h1111, 1'b0};
    vecs[8] = '{4'd2, 4'd3, 4'd3, OP_NOT, 16'h5A5A, 16'h0000, 4'b0100, 4'b1000, 4'b1000, 16'hA5A5, 1'b0};
    vecs[9] = '{4'd3, 4'd1, 4'd0, OP_SHR, 16'h8000, 16'h0000, 4'b1000, 4'b0010, 4'b0001, 16'h4000, 1'b0};

    b2b[0] = '{4'd1, 4'd2, 4'd3, OP_ADD, 16'h0, 16'h0, 4'b0, 4'b0, 4'b0, 16'h0005, 1'b0};
    b2b[1] = '{4'd3, 4'd0, 4'd0, OP_SUB, 16'h0, 16'h0, 4'b0, 4'b0, 4'b0, 16'h0004, 1'b0};
    b2b[2] = '{4'd0, 4'd1, 4'd2, OP_OR,  16'h0, 16'h0, 4'b0, 4'b0, 4'b0, 16'h0006, 1'b0};

    reset_word = {4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000};
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    ld_en = 1'b0;
    ld_idx = '0;
    ld_val = '0;
    bus_if.CmdValid = 1'b0;
    bus_if.CmdSrcA  = '0;
    bus_if.CmdSrcB  = '0;
    bus_if.CmdDst   = '0;
    bus_if.CmdOp    = '0;

    // Reset then idle
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_idle", 32'(cur_word()), 32'(reset_word));
    @(negedge clk);
    check("idle_hold", 32'(cur_word()), 32'(reset_word));

    // Table-driven single commands, including rejected indices
    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Back-to-back: CmdValid held with three queued commands
    preload(0, 16'h0001);
    preload(1, 16'h0002);
    preload(2, 16'h0003);
    preload(3, 16'h0000);
    idx = 0;
    last_done = -1000;
    prev_acc = -1000;
    drive_cmd(b2b[0]);
    bus_if.CmdValid = 1'b1;
    for (int c = 0; c < 100 && idx < 3; c++) begin
      @(negedge clk);
      if (bus_if.Done === 1'b1) last_done = c;
      if (bus_if.CmdReady === 1'b1) begin
        if (idx > 0) begin
          check($sformatf("b2b_accept%0d_after_done", idx), 32'(c - last_done), 32'd1);
          check($sformatf("b2b_accept%0d_interval", idx), 32'(c - prev_acc), 32'(Interval));
        end
        prev_acc = c;
        @(posedge clk);
        #1;
        idx++;
        if (idx < 3) drive_cmd(b2b[idx]);
        else bus_if.CmdValid = 1'b0;
      end
    end
    bus_if.CmdValid = 1'b0;
    check("b2b_accepted", 32'(idx), 32'd3);
    got_done = 1'b0;
    for (int c = 0; c < 50 && !got_done; c++) begin
      @(negedge clk);
      if (bus_if.Done === 1'b1) got_done = 1'b1;
    end
    check("b2b_last_done", 32'(got_done), 32'd1);
    @(negedge clk);
    check("b2b_r3", 32'(regs[3]), 32'h0005);
    check("b2b_r0", 32'(regs[0]), 32'h0004);
    check("b2b_r2", 32'(regs[2]), 32'h0006);
    check("b2b_r1", 32'(regs[1]), 32'h0002);

    // Reset in the cycle before WRITE: no write may follow
    preload(1, 16'h0005);
    preload(2, 16'h0003);
    preload(3, 16'hAAAA);
    @(negedge clk);
    drive_cmd(vecs[0]);
    bus_if.CmdValid = 1'b1;
    @(posedge clk);
    #1 bus_if.CmdValid = 1'b0;
    repeat (WriteCyc - 1) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("midop_reset_cyc%0d", k), 32'(cur_word()), 32'(reset_word));
    end
    check("midop_reset_no_write", 32'(regs[3]), 32'hAAAA);

    // Normal operation resumes after the abandoned op
    run_vec(10, vecs[0]);

    check("bus_invariant_violations", 32'(bus_viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
